// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative integer divider.
package div_unit_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic DIV_RES_QUO = 1'b0;
  localparam logic DIV_RES_REM = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, result negation on exit.
module div_sign_fix #(
  parameter int unsigned WIDTH = div_unit_pkg::WIDTH
) (
  input  logic             sign_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             dvd_neg,
  output logic             dvs_neg,
  output logic [WIDTH-1:0] dvd_mag,
  output logic [WIDTH-1:0] dvs_mag,
  input  logic [WIDTH-1:0] quo_mag,
  input  logic [WIDTH-1:0] rem_mag,
  input  logic             quo_neg,
  input  logic             rem_neg,
  output logic [WIDTH-1:0] quo_res,
  output logic [WIDTH-1:0] rem_res
);

  always_comb begin
    dvd_neg = sign_en & dividend[WIDTH-1];
    dvs_neg = sign_en & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? -dividend : dividend;
    dvs_mag = dvs_neg ? -divisor : divisor;
    quo_res = quo_neg ? -quo_mag : quo_mag;
    rem_res = rem_neg ? -rem_mag : rem_mag;
  end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per clock, signed/unsigned,
// returning quotient or remainder with a one-cycle done pulse.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = div_unit_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_is_div_inst,
  input  logic             ex_div_sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_done,
  input  logic             ex_div_res_sel,
  output logic [WIDTH-1:0] div_res
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             res_sel_q, res_sel_d;
  logic             div0_q, div0_d;
  logic             div_done_q, div_done_d;
  logic [WIDTH-1:0] div_res_q, div_res_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quo_res, rem_res;
  logic [WIDTH:0]   rem_sh, diff;
  logic             take;

  div_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .sign_en  (ex_div_sign),
    .dividend (dividend),
    .divisor  (divisor),
    .dvd_neg  (dvd_neg),
    .dvs_neg  (dvs_neg),
    .dvd_mag  (dvd_mag),
    .dvs_mag  (dvs_mag),
    .quo_mag  (quo_q),
    .rem_mag  (rem_q),
    .quo_neg  (quo_neg_q),
    .rem_neg  (rem_neg_q),
    .quo_res  (quo_res),
    .rem_res  (rem_res)
  );

  // quo_q doubles as the dividend shift register: its MSB feeds the remainder
  // while quotient bits enter at the LSB.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    take   = rem_sh[WIDTH] | ~diff[WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    res_sel_d  = res_sel_q;
    div0_d     = div0_q;
    div_done_d = 1'b0;
    div_res_d  = div_res_q;

    case (state_q)
      IDLE: begin
        if (ex_is_div_inst) begin
          state_d   = CALC;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = dvd_mag;
          dvs_d     = dvs_mag;
          quo_neg_d = dvd_neg ^ dvs_neg;
          rem_neg_d = dvd_neg;
          res_sel_d = ex_div_res_sel;
          div0_d    = (divisor == '0);
        end
      end
      CALC: begin
        if (!ex_is_div_inst) begin
          state_d = IDLE;
        end else begin
          rem_d = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], take};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        div_done_d = 1'b1;
        // Divide-by-zero quotient must bypass the sign correction.
        if (res_sel_q == DIV_RES_REM) begin
          div_res_d = rem_res;
        end else begin
          div_res_d = div0_q ? '1 : quo_res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      res_sel_q  <= 1'b0;
      div0_q     <= 1'b0;
      div_done_q <= 1'b0;
      div_res_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      res_sel_q  <= res_sel_d;
      div0_q     <= div0_d;
      div_done_q <= div_done_d;
      div_res_q  <= div_res_d;
    end
  end

  assign div_done = div_done_q;
  assign div_res  = div_res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, results, idle, abort, reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        sgn;
  logic        sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(
    .WIDTH(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_is_div_inst (req),
    .ex_div_sign    (sgn),
    .dividend       (a),
    .divisor        (b),
    .div_done       (done),
    .ex_div_res_sel (sel),
    .div_res        (res)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start(input logic s, input logic r, input logic [31:0] x, input logic [31:0] y);
    sgn = s;
    sel = r;
    a   = x;
    b   = y;
    req = 1'b1;
  endtask

  // Called #1 after a rising edge; the next edge samples the request.
  task automatic run_div(input string tag, input logic s, input logic r,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp);
    int k;
    k = 0;
    start(s, r, x, y);
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!done && k < 100);
    chk({tag, "_lat"}, k, 34);
    chk(tag, res, exp);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    req = 1'b0;
    sgn = 1'b0;
    sel = 1'b0;
    a   = '0;
    b   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", res, 32'd0);

    rst = 1'b0;
    run_div("s_rem_m8_m5", 1'b1, DIV_RES_REM, -32'sd8, -32'sd5, 32'hFFFF_FFFD);
    run_div("u_quo_99_11", 1'b0, DIV_RES_QUO, 32'd99, 32'd11, 32'd9);

    req  = 1'b0;
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("idle_done", seen, 32'd0);
    chk("idle_hold", res, 32'd9);

    run_div("s_quo_89_m11", 1'b1, DIV_RES_QUO, 32'd89, -32'sd11, 32'hFFFF_FFF8);

    run_div("u_div0_quo", 1'b0, DIV_RES_QUO, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    run_div("u_div0_rem", 1'b0, DIV_RES_REM, 32'h1234, 32'd0, 32'h0000_1234);
    run_div("s_div0_quo", 1'b1, DIV_RES_QUO, -32'sd7, 32'd0, 32'hFFFF_FFFF);
    run_div("s_div0_rem", 1'b1, DIV_RES_REM, -32'sd7, 32'd0, 32'hFFFF_FFF9);

    run_div("s_ovf_quo", 1'b1, DIV_RES_QUO, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("s_ovf_rem", 1'b1, DIV_RES_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_div("u_big_quo", 1'b0, DIV_RES_QUO, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_div("u_big_rem", 1'b0, DIV_RES_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

    // Abort after the request edge plus 10 CALC edges.
    start(1'b0, DIV_RES_QUO, 32'd1000, 32'd7);
    seen = 0;
    repeat (11) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    req = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("abort_done", seen, 32'd0);
    chk("abort_hold", res, 32'h8000_0000);
    run_div("after_abort", 1'b0, DIV_RES_QUO, 32'd1000, 32'd7, 32'd142);

    // Reset after the request edge plus 5 CALC edges.
    start(1'b1, DIV_RES_REM, -32'sd100, 32'd7);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_res", res, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    run_div("after_rst", 1'b1, DIV_RES_REM, -32'sd100, 32'd7, 32'hFFFF_FFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
